// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared constants and helpers for the pipelined adder.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   MAX_WIDTH              : widest operand the saturation helpers support
//   sat_max / sat_min      : largest / smallest two's-complement value of a width
//   sat_limit              : saturation value selected by the sign of operand a
// No ports (package).
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_STAGES = 4;
   localparam int unsigned MAX_WIDTH  = 64;

   // 2^(width-1)-1, zero-extended to MAX_WIDTH bits
   function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   // -2^(width-1) in width bits (only the sign bit set), zero-extended
   function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
      return 64'd1 << (width - 1);
   endfunction

   // Overflow can only push the result away from the operands' common sign,
   // so the sign of a alone picks the limit to clamp to.
   function automatic logic [MAX_WIDTH-1:0] sat_limit(input logic a_negative,
                                                      input int unsigned width);
      logic [MAX_WIDTH-1:0] limit;
      if (a_negative) begin
         limit = sat_min(width);
      end else begin
         limit = sat_max(width);
      end
      return limit;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operand / result handshake bundle of the pipelined adder.
//   in_valid, in_ready      : input handshake (transfer when both high)
//   a, b, cin               : operands and carry-in
//   out_valid, out_ready    : output handshake (transfer when both high)
//   sum, cout, ovf          : result, unsigned carry-out, signed overflow
// Modports: master = producer/consumer around the adder, slave = the adder.
// -----------------------------------------------------------------------------
interface pipelined_adder_if
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/pipelined_adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Purely combinational CHUNK-bit adder slice.
//   x, y : operand slices          ci : carry into the slice
//   s    : slice sum               co : carry out of the slice
//   cm   : carry into the slice MSB (cm ^ co is the signed overflow when this
//          slice holds the operand sign bits)
// -----------------------------------------------------------------------------
module adder_chunk
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned CHUNK = DEF_WIDTH / DEF_STAGES
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             cm
);

   logic [CHUNK:0] full_s;

   assign full_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
   assign s      = full_s[CHUNK-1:0];
   assign co     = full_s[CHUNK];
   // sum bit = x ^ y ^ carry_in, so the carry into the MSB is recovered by XOR
   assign cm     = full_s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// STAGES-deep carry-pipelined adder: stage k adds operand chunk k plus the
// carry registered by stage k-1. Upper operand chunks ride along with the
// transaction (skew) and finished lower sum chunks ride along too (deskew),
// so every chunk of a result leaves the last stage together.
// Latency STAGES cycles, one transaction per cycle, whole pipe freezes while
// the output is valid and not accepted.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipelined_adder_if.slave (in_valid/in_ready/a/b/cin,
//          out_valid/out_ready/sum/cout/ovf)
// Optional feature macro: PIPELINED_ADDER_SAT_EN -- saturate sum on signed
// overflow (ovf/cout still describe the unsaturated result).
// -----------------------------------------------------------------------------
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input logic                clk,
   input logic                rst,
   pipelined_adder_if.slave   bus
);

   // WIDTH must be an integer multiple of STAGES
   localparam int unsigned CHUNK = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   // pipeline registers, one entry per stage
   logic             valid_r [STAGES];
   logic [WIDTH-1:0] a_r     [STAGES];
   logic [WIDTH-1:0] b_r     [STAGES];
   logic [WIDTH-1:0] sum_r   [STAGES];
   logic             carry_r [STAGES];
   logic             ovf_r;

   // what each stage sees this cycle
   logic [WIDTH-1:0] stage_a_s    [STAGES];
   logic [WIDTH-1:0] stage_b_s    [STAGES];
   logic [WIDTH-1:0] stage_part_s [STAGES];
   logic             stage_ci_s   [STAGES];
   logic             stage_v_s    [STAGES];
   logic [CHUNK-1:0] chunk_sum_s  [STAGES];
   logic             chunk_co_s   [STAGES];
   logic             chunk_cm_s   [STAGES];
   logic [WIDTH-1:0] merged_s     [STAGES];

   logic             stall_s;
   logic             ovf_s;
   logic [WIDTH-1:0] final_sum_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // bit positions of chunk k within the word
      localparam logic [WIDTH-1:0] MASK =
         ((WIDTH'(1'b1) << CHUNK) - WIDTH'(1'b1)) << (k * CHUNK);

      if (k == 0) begin : g_first
         assign stage_a_s[k]    = bus.a;
         assign stage_b_s[k]    = bus.b;
         assign stage_part_s[k] = {WIDTH{1'b0}};
         assign stage_ci_s[k]   = bus.cin;
         assign stage_v_s[k]    = bus.in_valid;
      end else begin : g_next
         assign stage_a_s[k]    = a_r[k-1];
         assign stage_b_s[k]    = b_r[k-1];
         assign stage_part_s[k] = sum_r[k-1];
         assign stage_ci_s[k]   = carry_r[k-1];
         assign stage_v_s[k]    = valid_r[k-1];
      end

      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .x  (stage_a_s[k][k*CHUNK +: CHUNK]),
         .y  (stage_b_s[k][k*CHUNK +: CHUNK]),
         .ci (stage_ci_s[k]),
         .s  (chunk_sum_s[k]),
         .co (chunk_co_s[k]),
         .cm (chunk_cm_s[k])
      );

      // drop this stage's chunk into the partially built sum
      assign merged_s[k] = (stage_part_s[k] & ~MASK) |
                           (WIDTH'(chunk_sum_s[k]) << (k * CHUNK));
   end

   // a held output freezes every stage, bubbles included
   assign stall_s = valid_r[LAST] && !bus.out_ready;

   // the top chunk holds the sign bits, so its carries give signed overflow
   assign ovf_s = chunk_cm_s[LAST] ^ chunk_co_s[LAST];

`ifdef PIPELINED_ADDER_SAT_EN
   assign final_sum_s = ovf_s ? WIDTH'(sat_limit(stage_a_s[LAST][WIDTH-1], WIDTH))
                              : merged_s[LAST];
`else
   assign final_sum_s = merged_s[LAST];
`endif

   // Pipeline advance: every stage moves together unless the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_r[k] <= 1'b0;
            a_r[k]     <= {WIDTH{1'b0}};
            b_r[k]     <= {WIDTH{1'b0}};
            sum_r[k]   <= {WIDTH{1'b0}};
            carry_r[k] <= 1'b0;
         end
         ovf_r <= 1'b0;
      end else if (!stall_s) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            valid_r[k] <= stage_v_s[k];
            a_r[k]     <= stage_a_s[k];
            b_r[k]     <= stage_b_s[k];
            carry_r[k] <= chunk_co_s[k];
            if (k == LAST) begin
               sum_r[k] <= final_sum_s;
            end else begin
               sum_r[k] <= merged_s[k];
            end
         end
         ovf_r <= ovf_s;
      end
   end

   assign bus.in_ready  = !stall_s;
   assign bus.out_valid = valid_r[LAST];
   assign bus.sum       = sum_r[LAST];
   assign bus.cout      = carry_r[LAST];
   assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Directed bench for pipelined_adder: a table of hand-computed vectors run on
// STAGES=4, 1 and 16 instances (latency + result), a random back-pressured
// stream on the STAGES=4 instance against a reference sum, and reset corners.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid_d = 1'b0;
   logic [15:0] a_d = 16'h0000;
   logic [15:0] b_d = 16'h0000;
   logic        cin_d = 1'b0;
   logic        out_ready_d = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(16)) bus4 ();
   pipelined_adder_if #(.WIDTH(16)) bus1 ();
   pipelined_adder_if #(.WIDTH(16)) bus16 ();

   assign bus4.in_valid  = in_valid_d;
   assign bus4.a         = a_d;
   assign bus4.b         = b_d;
   assign bus4.cin       = cin_d;
   assign bus4.out_ready = out_ready_d;
   assign bus1.in_valid  = in_valid_d;
   assign bus1.a         = a_d;
   assign bus1.b         = b_d;
   assign bus1.cin       = cin_d;
   assign bus1.out_ready = 1'b1;
   assign bus16.in_valid  = in_valid_d;
   assign bus16.a         = a_d;
   assign bus16.b         = b_d;
   assign bus16.cin       = cin_d;
   assign bus16.out_ready = 1'b1;

   pipelined_adder #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
   pipelined_adder #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
   pipelined_adder #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
      res_t        r;
      logic [16:0] full;
      full   = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      r.sum  = full[15:0];
      r.cout = full[16];
      r.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
      if (SAT && r.ovf) r.sum = a[15] ? 16'h8000 : 16'h7FFF;
      return r;
   endfunction

   // Time limit on the whole run
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   vec_t vecs [12];
   res_t exp_q [$];

   initial begin
      int lat4, lat1, lat16, issued, received, seen;
      logic [15:0] s4, s1, s16, held_sum;
      logic c4, c1, c16, o4, o1, o16, held_v, held_cout, held_ovf;
      res_t e;

      vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
      vecs[3]  = '{16'h8000, 16'hFFFF, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
      vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6]  = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
      vecs[7]  = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h4000, 16'h4000, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
      vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b1, SAT ? 16'h7FFF : 16'hFFFF, 1'b0, 1'b1};
      vecs[11] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

      // ---- reset state (asynchronous, before any clock edge) ----
      out_ready_d = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("reset_out_valid", bus4.out_valid, 1'b0);
      check("reset_in_ready", bus4.in_ready, 1'b1);
      check("reset_sum", bus4.sum, 16'h0000);
      check("reset_cout_ovf", {bus4.cout, bus4.ovf}, 2'b00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      out_ready_d = 1'b1;

      // ---- table vectors: latency and result on all three depths ----
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid_d = 1'b1;
         a_d = vecs[i].a;
         b_d = vecs[i].b;
         cin_d = vecs[i].cin;
         lat4 = -1; lat1 = -1; lat16 = -1;
         s4 = 16'h0; s1 = 16'h0; s16 = 16'h0;
         c4 = 1'b0; c1 = 1'b0; c16 = 1'b0; o4 = 1'b0; o1 = 1'b0; o16 = 1'b0;
         for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) in_valid_d = 1'b0;
            if (bus4.out_valid && lat4 < 0) begin
               lat4 = c; s4 = bus4.sum; c4 = bus4.cout; o4 = bus4.ovf;
            end
            if (bus1.out_valid && lat1 < 0) begin
               lat1 = c; s1 = bus1.sum; c1 = bus1.cout; o1 = bus1.ovf;
            end
            if (bus16.out_valid && lat16 < 0) begin
               lat16 = c; s16 = bus16.sum; c16 = bus16.cout; o16 = bus16.ovf;
            end
         end
         check($sformatf("v%0d_lat_s4", i), lat4, 32'd4);
         check($sformatf("v%0d_sum_s4", i), s4, vecs[i].sum);
         check($sformatf("v%0d_cout_s4", i), c4, vecs[i].cout);
         check($sformatf("v%0d_ovf_s4", i), o4, vecs[i].ovf);
         check($sformatf("v%0d_lat_s1", i), lat1, 32'd1);
         check($sformatf("v%0d_res_s1", i), {s1, c1, o1}, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
         check($sformatf("v%0d_lat_s16", i), lat16, 32'd16);
         check($sformatf("v%0d_res_s16", i), {s16, c16, o16}, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
      end

      // ---- random stream with random back-pressure ----
      issued = 0; received = 0; held_v = 1'b0;
      held_sum = 16'h0; held_cout = 1'b0; held_ovf = 1'b0;
      for (int cyc = 0; cyc < 3000 && received < 100; cyc++) begin
         @(negedge clk);
         out_ready_d = 1'($urandom_range(0, 1));
         if (issued < 100 && $urandom_range(0, 3) != 0) begin
            in_valid_d = 1'b1;
            a_d = 16'($urandom);
            b_d = 16'($urandom);
            cin_d = 1'($urandom_range(0, 1));
         end else begin
            in_valid_d = 1'b0;
         end
         #1;
         if (held_v) begin
            check("stall_hold_valid", bus4.out_valid, 1'b1);
            check("stall_hold_result", {bus4.sum, bus4.cout, bus4.ovf}, {held_sum, held_cout, held_ovf});
         end
         check("stream_in_ready", bus4.in_ready, !(bus4.out_valid && !out_ready_d));
         if (bus4.out_valid && out_ready_d) begin
            if (exp_q.size() == 0) begin
               check("stream_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("stream_r%0d", received), {bus4.sum, bus4.cout, bus4.ovf}, {e.sum, e.cout, e.ovf});
            end
            received++;
         end
         if (in_valid_d && bus4.in_ready) begin
            exp_q.push_back(model(a_d, b_d, cin_d));
            issued++;
         end
         held_v = bus4.out_valid && !out_ready_d;
         held_sum = bus4.sum;
         held_cout = bus4.cout;
         held_ovf = bus4.ovf;
      end
      in_valid_d = 1'b0;
      out_ready_d = 1'b1;
      check("stream_received", received, 32'd100);
      repeat (20) @(negedge clk);

      // ---- reset with the pipe full and the output stalled ----
      out_ready_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_d = 1'b1;
         a_d = 16'h1111 + 16'(i);
         b_d = 16'h0101;
         cin_d = 1'b0;
         @(negedge clk);
      end
      in_valid_d = 1'b0;
      #1;
      check("rst_pre_out_valid", bus4.out_valid, 1'b1);
      check("rst_pre_in_ready", bus4.in_ready, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_async_out_valid", bus4.out_valid, 1'b0);
      check("rst_async_sum", bus4.sum, 16'h0000);
      check("rst_async_cout_ovf", {bus4.cout, bus4.ovf}, 2'b00);
      check("rst_async_in_ready", bus4.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      in_valid_d = 1'b1;
      a_d = 16'h00FF;
      b_d = 16'h0001;
      cin_d = 1'b0;
      out_ready_d = 1'b1;
      lat4 = -1; seen = 0; s4 = 16'h0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) in_valid_d = 1'b0;
         if (bus4.out_valid) begin
            seen++;
            if (lat4 < 0) begin
               lat4 = c; s4 = bus4.sum;
            end
         end
      end
      check("post_rst_latency", lat4, 32'd4);
      check("post_rst_result_count", seen, 32'd1);
      check("post_rst_sum", s4, 16'h0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth; WIDTH SHALL be an integer multiple of STAGES, and CHUNK = WIDTH/STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: two's-complement or unsigned operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have ports sum (WIDTH bits), cout (1 bit, unsigned carry-out) and ovf (1 bit, signed overflow), all outputs.

Function
REQ-012 The block SHALL form a transfer on any edge where in_valid && in_ready, and an output transfer where out_valid && out_ready.
REQ-013 Stage k (0..STAGES-1) SHALL add operand bits [k*CHUNK +: CHUNK] plus the carry registered by stage k-1 (stage 0 uses cin).
REQ-014 Upper operand chunks SHALL be skew-delayed, and lower sum chunks deskew-delayed, so all chunks of one transaction emerge together.
REQ-015 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure; throughput SHALL be one transaction per cycle.
REQ-016 The sum SHALL equal (a + b + cin) mod 2^WIDTH; cout SHALL be bit WIDTH of the full sum.
REQ-017 ovf SHALL be 1 iff a[WIDTH-1] == b[WIDTH-1] and the wrapped sum[WIDTH-1] differs from them.
REQ-018 The stall condition SHALL be out_valid && !out_ready; during a stall every pipeline register, including the valid bits, SHALL hold its value.
REQ-019 in_ready SHALL equal !stall (combinational); no transaction SHALL be lost, duplicated or reordered.
REQ-020 Bubbles SHALL propagate as invalid stages; the design SHALL NOT collapse bubbles.
REQ-021 sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 STAGES=1 SHALL degenerate to a single registered adder with 1-cycle latency.

Reset
REQ-023 While rst=1, all valid bits, sum, cout and ovf SHALL be 0 immediately and asynchronously, and in_ready SHALL be 1.
REQ-024 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear after reset is released.
REQ-025 The first input transfer SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-026 With macro PIPELINED_ADDER_SAT_EN defined, sum SHALL saturate whenever ovf=1: to 2^(WIDTH-1)-1 if a is non-negative, and to -2^(WIDTH-1) if a is negative. ovf and cout SHALL still report the unsaturated result.
REQ-027 Without PIPELINED_ADDER_SAT_EN, sum SHALL wrap and no saturation logic SHALL be present.

Structure
REQ-028 Shared package pipelined_adder_pkg SHALL hold the default WIDTH/STAGES constants and the saturation-limit constants/functions.
REQ-029 One sub-module, adder_chunk (CHUNK-bit combinational add with carry-in/out and MSB carry for ovf), SHALL be instantiated STAGES times.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-030 a=0x00FF, b=0x0001, cin=0, out_ready=1 -> after 4 cycles sum=0x0100, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all stages).
REQ-032 a=0x7FFF, b=0x0001 -> ovf=1, cout=0; sum=0x8000 without the macro; sum=0x7FFF with PIPELINED_ADDER_SAT_EN. a=0x8000, b=0xFFFF -> ovf=1, cout=1; sum=0x7FFF wrapped or 0x8000 saturated.
REQ-033 Random back-to-back stream of 100 transactions with out_ready toggled randomly -> results match the model in order, and in_ready=0 exactly on stall cycles.
REQ-034 Assert rst for one cycle with 3 transactions in flight -> out_valid=0 immediately and no stale result afterwards; a new transaction issued after reset returns correctly in 4 cycles.
REQ-035 STAGES=1 and STAGES=16 builds with REQ-030/031 vectors -> latency 1 and 16 respectively, same results.
